// File: rtl/branch_recovery_unit_if.sv
// Bus bundle for branch_recovery_unit: fetch-side allocation, execute-side
// resolution and the recovery outputs (flush / redirect / occupancy).
// master = the pipeline driving allocations and resolutions,
// slave  = the recovery unit itself.
interface branch_recovery_unit_if #(
  parameter int WordSize = 32,
  parameter int Depth    = 4
);
  logic                       alloc_valid;
  logic                       alloc_ready;
  logic [WordSize-1:0]        alloc_pc;
  logic                       alloc_pred_taken;
  logic [WordSize-1:0]        alloc_pred_target;

  logic                       res_valid;
  logic                       res_taken;
  logic [WordSize-1:0]        res_target;

  logic                       flush;
  logic                       npc_valid;
  logic [WordSize-1:0]        npc;
  logic [$clog2(Depth):0]     count;

  modport master (
    output alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
    output res_valid, res_taken, res_target,
    input  alloc_ready, flush, npc_valid, npc, count
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
    input  res_valid, res_taken, res_target,
    output alloc_ready, flush, npc_valid, npc, count
  );
endinterface

// File: rtl/branch_recovery_unit.sv
// Branch recovery unit: keeps an in-order queue of up to Depth predicted
// branches, resolves the oldest one, and on a direction or target mispredict
// raises a multi-cycle flush, redirects fetch through npc and squashes every
// younger entry.
// Optional feature: define BRANCH_RECOVERY_STATS_EN to add the saturating
// stat_resolved / stat_mispred counters and their output ports.
module branch_recovery_unit #(
  parameter int                  WordSize    = 32,
  parameter int                  Depth       = 4,
  parameter int                  FlushCycles = 1,
  parameter int                  InstBytes   = 4,
  parameter logic [WordSize-1:0] ResetVector = '0
) (
  input  logic                   clk,
  input  logic                   rstn,
  branch_recovery_unit_if.slave  bus
`ifdef BRANCH_RECOVERY_STATS_EN
  ,
  output logic [31:0]            stat_resolved,
  output logic [31:0]            stat_mispred
`endif
);

  localparam int PtrW   = $clog2(Depth);
  localparam int CountW = PtrW + 1;
  localparam int FcW    = $clog2(FlushCycles + 1);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  // Reject configurations the pointer arithmetic cannot support.
  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("branch_recovery_unit: Depth must be a power of two >= 2");
  end
  if (FlushCycles < 1) begin : g_bad_flush
    $error("branch_recovery_unit: FlushCycles must be >= 1");
  end

  logic [1:0]          state;
  logic [PtrW-1:0]     head;
  logic [PtrW-1:0]     tail;
  logic [CountW-1:0]   count_q;
  logic [FcW-1:0]      flush_left;
  logic                flush_q;
  logic                npc_valid_q;
  logic [WordSize-1:0] npc_q;

  logic [WordSize-1:0] pc_mem     [Depth];
  logic                taken_mem  [Depth];
  logic [WordSize-1:0] target_mem [Depth];

  logic                full;
  logic                empty;
  logic                ready;
  logic                alloc_fire;
  logic                res_fire;
  logic                mispredict;
  logic                resolve_ok;
  logic [WordSize-1:0] head_pc;
  logic                head_taken;
  logic [WordSize-1:0] head_target;
  logic [WordSize-1:0] fall_through;
  logic [WordSize-1:0] correct_pc;

  assign full    = (count_q == CountW'(Depth));
  assign empty   = (count_q == '0);
  assign ready   = (state == RUN) && !full;

  assign alloc_fire = bus.alloc_valid && ready;
  // Resolutions only count in RUN with something queued; an empty queue
  // has nothing to compare against.
  assign res_fire   = (state == RUN) && bus.res_valid && !empty;

  assign head_pc      = pc_mem[head];
  assign head_taken   = taken_mem[head];
  assign head_target  = target_mem[head];
  // Fall-through wraps modulo 2^WordSize; the carry is intentionally lost.
  assign fall_through = head_pc + WordSize'(InstBytes);
  assign correct_pc   = bus.res_taken ? bus.res_target : fall_through;

  // A target only matters when both prediction and outcome are taken.
  assign mispredict = res_fire &&
                      ((bus.res_taken != head_taken) ||
                       (bus.res_taken && (bus.res_target != head_target)));
  assign resolve_ok = res_fire && !mispredict;

  // Capture the predicted branch at the tail slot; a same-cycle mispredict
  // squashes it because it is younger than the branch being resolved.
  always_ff @(posedge clk) begin
    if (alloc_fire && !mispredict) begin
      pc_mem[tail]     <= bus.alloc_pc;
      taken_mem[tail]  <= bus.alloc_pred_taken;
      target_mem[tail] <= bus.alloc_pred_target;
    end
  end

  // Control FSM: boot redirect, normal queue bookkeeping, and flush timing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= BOOT;
      head        <= '0;
      tail        <= '0;
      count_q     <= '0;
      flush_left  <= '0;
      flush_q     <= 1'b0;
      npc_valid_q <= 1'b0;
      npc_q       <= '0;
    end else begin
      case (state)
        BOOT: begin
          if (!npc_valid_q) begin
            npc_valid_q <= 1'b1;
            npc_q       <= ResetVector;
          end else begin
            npc_valid_q <= 1'b0;
            state       <= RUN;
          end
        end

        RUN: begin
          if (mispredict) begin
            flush_q     <= 1'b1;
            npc_valid_q <= 1'b1;
            npc_q       <= correct_pc;
            head        <= tail;
            count_q     <= '0;
            flush_left  <= FcW'(FlushCycles - 1);
            state       <= FLUSH;
          end else begin
            if (alloc_fire) begin
              tail <= tail + PtrW'(1);
            end
            if (resolve_ok) begin
              head <= head + PtrW'(1);
            end
            case ({alloc_fire, resolve_ok})
              2'b10:   count_q <= count_q + CountW'(1);
              2'b01:   count_q <= count_q - CountW'(1);
              default: count_q <= count_q;
            endcase
          end
        end

        FLUSH: begin
          npc_valid_q <= 1'b0;
          if (flush_left == '0) begin
            flush_q <= 1'b0;
            state   <= RUN;
          end else begin
            flush_left <= flush_left - FcW'(1);
          end
        end

        default: begin
          flush_q     <= 1'b0;
          npc_valid_q <= 1'b0;
          state       <= BOOT;
        end
      endcase
    end
  end

  assign bus.alloc_ready = ready;
  assign bus.flush       = flush_q;
  assign bus.npc_valid   = npc_valid_q;
  assign bus.npc         = npc_q;
  assign bus.count       = count_q;

`ifdef BRANCH_RECOVERY_STATS_EN
  logic [31:0] resolved_q;
  logic [31:0] mispred_q;

  // Saturating event counters for accepted resolutions and mispredicts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resolved_q <= '0;
      mispred_q  <= '0;
    end else begin
      if (res_fire && (resolved_q != 32'hFFFF_FFFF)) begin
        resolved_q <= resolved_q + 32'd1;
      end
      if (mispredict && (mispred_q != 32'hFFFF_FFFF)) begin
        mispred_q <= mispred_q + 32'd1;
      end
    end
  end

  assign stat_resolved = resolved_q;
  assign stat_mispred  = mispred_q;
`endif

endmodule

// File: tb/tb_branch_recovery_unit.sv
// Testbench for branch_recovery_unit: a table of single-cycle vectors for
// the main resolve/mispredict paths plus hand-written sequences for boot,
// pointer wrap and reset in the middle of a queue or a flush.
module tb_branch_recovery_unit;

  localparam int          WordSize    = 32;
  localparam int          Depth       = 4;
  localparam int          FlushCycles = 3;
  localparam int          InstBytes   = 4;
  localparam logic [31:0] ResetVector = 32'h0000_1000;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  branch_recovery_unit_if #(.WordSize(WordSize), .Depth(Depth)) bus ();

`ifdef BRANCH_RECOVERY_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispred;
`endif

  branch_recovery_unit #(
    .WordSize   (WordSize),
    .Depth      (Depth),
    .FlushCycles(FlushCycles),
    .InstBytes  (InstBytes),
    .ResetVector(ResetVector)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
`ifdef BRANCH_RECOVERY_STATS_EN
    ,
    .stat_resolved(stat_resolved),
    .stat_mispred (stat_mispred)
`endif
  );

  typedef struct {
    string       name;
    logic        av;
    logic [31:0] apc;
    logic        at;
    logic [31:0] atgt;
    logic        rv;
    logic        rt;
    logic [31:0] rtgt;
    logic        ef;
    logic        env;
    logic [31:0] enpc;
    logic [31:0] ecnt;
    logic        erdy;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Give up rather than hang if the bench ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "[TB] timeout");
  end

  task automatic addV(input string name, input logic av, input logic [31:0] apc,
                      input logic at, input logic [31:0] atgt, input logic rv,
                      input logic rt, input logic [31:0] rtgt, input logic ef,
                      input logic env, input logic [31:0] enpc,
                      input logic [31:0] ecnt, input logic erdy);
    vec_t v;
    v.name = name; v.av = av; v.apc = apc; v.at = at; v.atgt = atgt;
    v.rv = rv; v.rt = rt; v.rtgt = rtgt; v.ef = ef; v.env = env;
    v.enpc = enpc; v.ecnt = ecnt; v.erdy = erdy;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic setInputs(input logic av, input logic [31:0] apc, input logic at,
                           input logic [31:0] atgt, input logic rv, input logic rt,
                           input logic [31:0] rtgt);
    bus.alloc_valid       = av;
    bus.alloc_pc          = apc;
    bus.alloc_pred_taken  = at;
    bus.alloc_pred_target = atgt;
    bus.res_valid         = rv;
    bus.res_taken         = rt;
    bus.res_target        = rtgt;
  endtask

  task automatic applyStimulus(input vec_t v);
    setInputs(v.av, v.apc, v.at, v.atgt, v.rv, v.rt, v.rtgt);
  endtask

  task automatic checkOutput(input vec_t v);
    checkVal({v.name, "_flush"}, 32'(bus.flush), 32'(v.ef));
    checkVal({v.name, "_npc_valid"}, 32'(bus.npc_valid), 32'(v.env));
    if (v.env) checkVal({v.name, "_npc"}, bus.npc, v.enpc);
    checkVal({v.name, "_count"}, 32'(bus.count), v.ecnt);
    checkVal({v.name, "_ready"}, 32'(bus.alloc_ready), 32'(v.erdy));
  endtask

  // Wait a bounded number of cycles for the boot redirect, then check it
  // and the first RUN cycle that follows.
  task automatic bootCheck(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (bus.npc_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s_boot_redirect: got npc_valid=0 expected npc_valid=1 within 4 cycles", tag);
    end else begin
      checkVal({tag, "_boot_npc"}, bus.npc, ResetVector);
      checkVal({tag, "_boot_flush"}, 32'(bus.flush), 32'd0);
      checkVal({tag, "_boot_ready"}, 32'(bus.alloc_ready), 32'd0);
    end
    tick();
    checkVal({tag, "_run_ready"}, 32'(bus.alloc_ready), 32'd1);
    checkVal({tag, "_run_npc_valid"}, 32'(bus.npc_valid), 32'd0);
    checkVal({tag, "_run_count"}, 32'(bus.count), 32'd0);
  endtask

  initial begin
    logic [31:0] pcs [Depth];

    // name, alloc(v,pc,taken,target), res(v,taken,target), expect(flush,npc_valid,npc,count,ready)
    addV("alloc_tk",    1, 32'h40,  1, 32'h80, 0, 0, 0,      0, 0, 0,      1, 1);
    addV("res_tk_ok",   0, 0,       0, 0,      1, 1, 32'h80, 0, 0, 0,      0, 1);
    addV("alloc_nt",    1, 32'h50,  0, 0,      0, 0, 0,      0, 0, 0,      1, 1);
    addV("res_nt_ok",   0, 0,       0, 0,      1, 0, 0,      0, 0, 0,      0, 1);
    addV("res_empty",   0, 0,       0, 0,      1, 1, 32'h999,0, 0, 0,      0, 1);
    addV("alloc_tk2",   1, 32'h40,  1, 32'h80, 0, 0, 0,      0, 0, 0,      1, 1);
    addV("tgt_misp",    0, 0,       0, 0,      1, 1, 32'h90, 1, 1, 32'h90, 0, 0);
    addV("flush2_ign",  1, 32'h123, 1, 32'h8,  1, 1, 32'h4,  1, 0, 0,      0, 0);
    addV("flush3",      0, 0,       0, 0,      0, 0, 0,      1, 0, 0,      0, 0);
    addV("flush_end",   0, 0,       0, 0,      0, 0, 0,      0, 0, 0,      0, 1);
    addV("alloc_100",   1, 32'h100, 0, 0,      0, 0, 0,      0, 0, 0,      1, 1);
    addV("dir_misp",    0, 0,       0, 0,      1, 1, 32'h200,1, 1, 32'h200,0, 0);
    addV("dir_fl2",     0, 0,       0, 0,      0, 0, 0,      1, 0, 0,      0, 0);
    addV("dir_fl3",     0, 0,       0, 0,      0, 0, 0,      1, 0, 0,      0, 0);
    addV("dir_end",     0, 0,       0, 0,      0, 0, 0,      0, 0, 0,      0, 1);
    addV("alloc_top",   1, 32'hFFFF_FFFC, 1, 32'h10, 0, 0, 0, 0, 0, 0,     1, 1);
    addV("wrap_misp",   0, 0,       0, 0,      1, 0, 0,      1, 1, 32'h0,  0, 0);
    addV("wrap_fl2",    0, 0,       0, 0,      0, 0, 0,      1, 0, 0,      0, 0);
    addV("wrap_fl3",    0, 0,       0, 0,      0, 0, 0,      1, 0, 0,      0, 0);
    addV("wrap_end",    0, 0,       0, 0,      0, 0, 0,      0, 0, 0,      0, 1);
    addV("fill1",       1, 32'h1000,0, 0,      0, 0, 0,      0, 0, 0,      1, 1);
    addV("fill2",       1, 32'h1004,0, 0,      0, 0, 0,      0, 0, 0,      2, 1);
    addV("fill3",       1, 32'h1008,0, 0,      0, 0, 0,      0, 0, 0,      3, 1);
    addV("fill4_full",  1, 32'h100C,0, 0,      0, 0, 0,      0, 0, 0,      4, 0);
    addV("full_rej",    1, 32'h2000,0, 0,      1, 0, 0,      0, 0, 0,      3, 1);
    addV("alloc_res",   1, 32'h1010,0, 0,      1, 0, 0,      0, 0, 0,      3, 1);
    addV("drain1",      0, 0,       0, 0,      1, 0, 0,      0, 0, 0,      2, 1);
    addV("drain2",      0, 0,       0, 0,      1, 0, 0,      0, 0, 0,      1, 1);
    addV("drain3",      0, 0,       0, 0,      1, 0, 0,      0, 0, 0,      0, 1);
    addV("alloc_600",   1, 32'h600, 0, 0,      0, 0, 0,      0, 0, 0,      1, 1);
    addV("misp_drop",   1, 32'h604, 0, 0,      1, 1, 32'h700,1, 1, 32'h700,0, 0);
    addV("drop_fl2",    0, 0,       0, 0,      0, 0, 0,      1, 0, 0,      0, 0);
    addV("drop_fl3",    0, 0,       0, 0,      0, 0, 0,      1, 0, 0,      0, 0);
    addV("drop_end",    0, 0,       0, 0,      0, 0, 0,      0, 0, 0,      0, 1);

    rstn = 1'b0;
    setInputs(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    checkVal("rst_flush", 32'(bus.flush), 32'd0);
    checkVal("rst_npc_valid", 32'(bus.npc_valid), 32'd0);
    checkVal("rst_npc", bus.npc, 32'd0);
    checkVal("rst_count", 32'(bus.count), 32'd0);
    checkVal("rst_ready", 32'(bus.alloc_ready), 32'd0);
    @(posedge clk);
    #3 rstn = 1'b1;
    bootCheck("init");

    $display("[TB] running %0d table vectors", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput(vecs[i]);
    end
    setInputs(0, 0, 0, 0, 0, 0, 0);

    // Three full fill/drain rounds so head and tail wrap repeatedly.
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < Depth; j++) begin
        pcs[j] = 32'h3000 + 32'((r * Depth + j) * 16);
        setInputs(1, pcs[j], 1, pcs[j] + 32'h400, 0, 0, 0);
        tick();
        checkVal($sformatf("wrap_r%0d_fill%0d_count", r, j), 32'(bus.count), 32'(j + 1));
      end
      setInputs(0, 0, 0, 0, 0, 0, 0);
      checkVal($sformatf("wrap_r%0d_full_ready", r), 32'(bus.alloc_ready), 32'd0);
      for (int j = 0; j < Depth; j++) begin
        setInputs(0, 0, 0, 0, 1, 1, pcs[j] + 32'h400);
        tick();
        checkVal($sformatf("wrap_r%0d_res%0d_flush", r, j), 32'(bus.flush), 32'd0);
        checkVal($sformatf("wrap_r%0d_res%0d_count", r, j), 32'(bus.count), 32'(Depth - 1 - j));
      end
      setInputs(0, 0, 0, 0, 0, 0, 0);
    end

    // Stored PC survives the wraps: fall-through redirect after pointer reuse.
    setInputs(1, 32'h5000, 1, 32'h5400, 0, 0, 0);
    tick();
    setInputs(0, 0, 0, 0, 1, 0, 0);
    tick();
    setInputs(0, 0, 0, 0, 0, 0, 0);
    checkVal("post_wrap_flush", 32'(bus.flush), 32'd1);
    checkVal("post_wrap_npc", bus.npc, 32'h5004);
    repeat (FlushCycles) tick();
    checkVal("post_wrap_flush_end", 32'(bus.flush), 32'd0);

    // Reset with entries queued drops the occupancy at once.
    setInputs(1, 32'h800, 0, 0, 0, 0, 0);
    tick();
    tick();
    setInputs(0, 0, 0, 0, 0, 0, 0);
    checkVal("midq_count", 32'(bus.count), 32'd2);
    #2 rstn = 1'b0;
    #1;
    checkVal("midq_rst_count", 32'(bus.count), 32'd0);
    checkVal("midq_rst_ready", 32'(bus.alloc_ready), 32'd0);
    @(posedge clk);
    #3 rstn = 1'b1;
    bootCheck("midq");

    // Reset in the middle of a flush clears flush without waiting for a clock.
    setInputs(1, 32'h100, 0, 0, 0, 0, 0);
    tick();
    setInputs(0, 0, 0, 0, 1, 1, 32'h200);
    tick();
    setInputs(0, 0, 0, 0, 0, 0, 0);
    checkVal("midfl_flush", 32'(bus.flush), 32'd1);
    tick();
    checkVal("midfl_flush2", 32'(bus.flush), 32'd1);
    #2 rstn = 1'b0;
    #1;
    checkVal("midfl_rst_flush", 32'(bus.flush), 32'd0);
    checkVal("midfl_rst_npc_valid", 32'(bus.npc_valid), 32'd0);
    @(posedge clk);
    #3 rstn = 1'b1;
    bootCheck("midfl");

    setInputs(1, 32'h700, 0, 0, 0, 0, 0);
    tick();
    setInputs(0, 0, 0, 0, 0, 0, 0);
    checkVal("reboot_alloc_count", 32'(bus.count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
